// File: rtl/modn_pkg.sv
// Shared constants and width helper for the modulo-N counter family.
package modn_pkg;

  localparam int MODE_MOORE = 0;
  localparam int MODE_MEALY = 1;

  // Counter width: enough bits for 0..modulus-1, never narrower than one bit.
  function automatic int cnt_width(input int modulus);
    int w;
    w = $clog2(modulus);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sat_event_counter.sv
// Saturating event counter: counts inc pulses, sticks at all ones, clr wins over inc.
module sat_event_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] value,
  output logic             sat
);

  assign sat = &value;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      value <= '0;
    end else if (inc && !sat) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/modn_counter.sv
// Up/down modulo-MODULUS counter with load, Moore/Mealy terminal count
// and a saturating count of wrap events.
module modn_counter
  import modn_pkg::*;
#(
  parameter int MODULUS = 5,
  parameter int MEALY   = MODE_MOORE,
  parameter int WRAP_W  = 8,
  localparam int W      = cnt_width(MODULUS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              dir,
  input  logic              load,
  input  logic [W-1:0]      load_val,
  input  logic              clr_wrap,
  output logic [W-1:0]      count,
  output logic              tc,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              wrap_sat
);

  localparam logic [W-1:0] MAX = W'(MODULUS - 1);

  logic [W-1:0] count_nxt;
  logic         count_ok;
  logic         load_ok;
  logic         at_max;
  logic         at_zero;
  logic         wrap_evt;

  // When MODULUS fills the whole code space every encoding is legal.
  if (MODULUS == (1 << W)) begin : g_full_range
    assign count_ok = 1'b1;
    assign load_ok  = 1'b1;
  end else begin : g_part_range
    assign count_ok = (count <= MAX);
    assign load_ok  = (load_val <= MAX);
  end

  assign at_max   = count_ok && (count == MAX);
  assign at_zero  = (count == '0);
  assign wrap_evt = en && !load && !rst && ((dir && at_max) || (!dir && at_zero));

  always_comb begin
    count_nxt = count;
    if (!count_ok) begin
      count_nxt = '0;
    end else if (load) begin
      count_nxt = load_ok ? load_val : '0;
    end else if (en) begin
      if (dir) begin
        count_nxt = at_max ? '0 : count + 1'b1;
      end else begin
        count_nxt = at_zero ? MAX : count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

  // Moore flags the state itself; Mealy flags the edge that is about to wrap.
  if (MEALY == MODE_MEALY) begin : g_tc_mealy
    assign tc = wrap_evt;
  end else begin : g_tc_moore
    assign tc = at_max && !rst;
  end

  sat_event_counter #(
    .WIDTH (WRAP_W)
  ) u_wrap_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_wrap),
    .inc   (wrap_evt),
    .value (wrap_cnt),
    .sat   (wrap_sat)
  );

endmodule

// File: doc/modn_counter.md
MODN_COUNTER -- requirements
Module: modn_counter

Interface
REQ-001 Parameter MODULUS, default 5: count modulus, legal range >= 2.
REQ-002 Parameter MEALY, default 0: tc mode, 0 = Moore, 1 = Mealy.
REQ-003 Parameter WRAP_W, default 8: width of the wrap event counter.
REQ-004 Derived localparam W SHALL be max(1, clog2(MODULUS)).
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 en  in  1  count enable.
REQ-008 dir  in  1  direction: 1 = up, 0 = down.
REQ-009 load  in  1  synchronous load strobe.
REQ-010 load_val  in  W  value to load.
REQ-011 clr_wrap  in  1  synchronous clear of wrap_cnt.
REQ-012 count  out  W  present count, always in 0..MODULUS-1.
REQ-013 tc  out  1  terminal-count event, combinational.
REQ-014 wrap_cnt  out  WRAP_W  number of wraps since reset or clear, saturating.
REQ-015 wrap_sat  out  1  high when wrap_cnt equals all ones.

Function
REQ-016 count update priority SHALL be rst > load > en; with none active, count holds.
REQ-017 load: count <= load_val if load_val < MODULUS, else 0.
REQ-018 en & dir=1: count <= 0 if count == MODULUS-1, else count+1.
REQ-019 en & dir=0: count <= MODULUS-1 if count == 0, else count-1.
REQ-020 Any count >= MODULUS SHALL be treated as illegal; next count is 0 regardless of inputs, except rst.
REQ-021 A wrap event SHALL be en & ~load & ~rst & ((dir & count==MODULUS-1) | (~dir & count==0)).
REQ-022 MEALY=0: tc = (count == MODULUS-1), a function of state only.
REQ-023 MEALY=1: tc = wrap event (REQ-021), high in the cycle before the wrapping edge.
REQ-024 tc SHALL be forced 0 while rst is high, in both modes.
REQ-025 wrap_cnt SHALL increment by 1 on each edge with a wrap event, and hold at all ones once reached.
REQ-026 clr_wrap SHALL set wrap_cnt to 0 and take priority over a coincident wrap event.
REQ-027 load and the wrap counter are independent; a load never changes wrap_cnt.
REQ-028 A power-of-two MODULUS SHALL behave identically; the wrap comes from the compare, not from natural overflow.

Reset
REQ-029 On rst at a rising edge: count = 0, wrap_cnt = 0, wrap_sat = 0.
REQ-030 rst SHALL abort any operation mid-count; no load or count occurs on that edge.
REQ-031 No asynchronous reset path shall exist.

Structure
REQ-032 Shared package modn_pkg SHALL hold the constants MODE_MOORE=0 and MODE_MEALY=1, plus the width helper function used for W.
REQ-033 The saturating wrap counter SHALL be a sub-module sat_event_counter (parameter WIDTH; ports clk, rst, clr, inc, value, sat).
REQ-034 Next-state logic and the state register SHALL be separate processes; tc SHALL be purely combinational.

Verification
REQ-035 MODULUS=5, MEALY=0: rst, then en=1 dir=1 for 6 edges -> count 1,2,3,4,0,1; tc=1 only while count==4; wrap_cnt=1.
REQ-036 MEALY=1: from count 0 with en=1 dir=0 -> tc=1 in that cycle, then count=4 and wrap_cnt=1; with en=0 at count 0 -> tc=0.
REQ-037 load_val=7 (W=3) -> count 0; load=1 en=1 load_val=3 at count 4 dir=1 -> count 3, tc low, wrap_cnt unchanged.
REQ-038 WRAP_W=2: 4 wraps -> wrap_cnt=3, wrap_sat=1; a 5th wrap holds 3; clr_wrap coincident with a wrap -> wrap_cnt 0.
REQ-039 count=3, en=1, rst pulsed for one edge -> count 0, wrap_cnt 0, tc 0 during rst; counting resumes 1,2,... afterwards.
REQ-040 MODULUS=8, dir=1 -> count wraps 7->0 with tc (Moore) at 7; dir=0 from 0 -> 7.
